// File: rtl/sa_pkg.sv
// Shared types and default dimensions for the systolic-array sequencer.
// The optional SA_SEQ_PERFCNT_EN build adds performance counters to sa_sequencer.
package sa_pkg;

    localparam int SA_ROWS     = 8;
    localparam int SA_INWIDTH  = 8;
    localparam int SA_OUTWIDTH = 32;

    // Raw encodings kept for tools and scripts that expect plain constants
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        FLUSH = ST_FLUSH,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/sa_seq_cnt.sv
// Loadable up-counter with a terminal-count flag; used for the beat, flush and row counts.
module sa_seq_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority so a counter can be re-armed in the same cycle it would count
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == term);

endmodule

// File: rtl/sa_sequencer.sv
// Job sequencer for an output-stationary systolic array: load K operand beats, flush, drain ROWS results.
// Define SA_SEQ_PERFCNT_EN to add the perf_cycles / perf_stalls counters.
module sa_sequencer
    import sa_pkg::*;
#(
    parameter int ROWS      = SA_ROWS,
    parameter int INWIDTH   = SA_INWIDTH,
    parameter int OUTWIDTH  = SA_OUTWIDTH,
    parameter int KW        = 16,
    parameter int FLUSH_CYC = 3*ROWS-2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               job_valid,
    output logic                               job_ready,
    input  logic [KW-1:0]                      job_k,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [ROWS-1:0][INWIDTH-1:0]       src_a,
    input  logic [ROWS-1:0][INWIDTH-1:0]       src_w,
    output logic                               core_inpvalid,
    output logic [ROWS-1:0][INWIDTH-1:0]       core_ain,
    output logic [ROWS-1:0][INWIDTH-1:0]       core_win,
    input  logic [ROWS-1:0][OUTWIDTH-1:0]      core_rout,
    input  logic [ROWS-1:0]                    core_rvalid,
    output logic                               core_outread,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [ROWS-1:0][OUTWIDTH-1:0]      res_data,
    output logic                               res_last,
    output logic                               busy,
    output logic                               done
`ifdef SA_SEQ_PERFCNT_EN
    ,
    output logic [31:0]                        perf_cycles,
    output logic [31:0]                        perf_stalls
`endif
);

    localparam int FW = $clog2(FLUSH_CYC + 1);
    localparam int RW = $clog2(ROWS + 1);

    seq_state_t    state_q, state_d;
    logic [KW-1:0] job_k_q, job_k_d;
    logic          job_fire, src_fire, res_fire;
    logic          beat_tc, flush_tc, row_tc;

    // Every handshake output is gated by rst so the block is silent while reset is held
    assign job_ready     = !rst && (state_q == IDLE);
    assign src_ready     = !rst && (state_q == LOAD);
    assign job_fire      = job_valid && job_ready;
    assign src_fire      = src_valid && src_ready;
    assign res_valid     = !rst && (state_q == DRAIN) && (&core_rvalid);
    assign res_fire      = res_valid && res_ready;
    assign core_inpvalid = src_fire;
    assign core_ain      = src_fire ? src_a : '0;
    assign core_win      = src_fire ? src_w : '0;
    assign core_outread  = res_fire;
    assign res_data      = (!rst && (state_q == DRAIN)) ? core_rout : '0;
    assign res_last      = res_valid && row_tc;
    assign busy          = !rst && (state_q != IDLE);
    assign done          = !rst && (state_q == DONE);

    sa_seq_cnt #(.W(KW)) u_beat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (job_fire),
        .load_val ('0),
        .inc      (src_fire),
        .term     (job_k_q - 1'b1),
        .tc       (beat_tc)
    );

    // Held at zero throughout LOAD so FLUSH always starts from a clean count
    sa_seq_cnt #(.W(FW)) u_flush_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == LOAD),
        .load_val ('0),
        .inc      (state_q == FLUSH),
        .term     (FW'(FLUSH_CYC - 1)),
        .tc       (flush_tc)
    );

    sa_seq_cnt #(.W(RW)) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == FLUSH),
        .load_val ('0),
        .inc      (res_fire),
        .term     (RW'(ROWS - 1)),
        .tc       (row_tc)
    );

    always_comb begin
        state_d = state_q;
        job_k_d = job_k_q;
        unique case (state_q)
            IDLE: begin
                if (job_fire) begin
                    job_k_d = job_k;
                    state_d = (job_k != '0) ? LOAD : DONE;
                end
            end
            LOAD:    if (src_fire && beat_tc) state_d = FLUSH;
            FLUSH:   if (flush_tc)            state_d = DRAIN;
            DRAIN:   if (res_fire && row_tc)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            job_k_q <= '0;
        end else begin
            state_q <= state_d;
            job_k_q <= job_k_d;
        end
    end

`ifdef SA_SEQ_PERFCNT_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stalls_q, perf_stalls_d;

    // Counting stops on entry to DONE so the values describe the finished job until the next accept
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (job_fire) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else if (state_q != IDLE && state_q != DONE) begin
            perf_cycles_d = perf_cycles_q + 32'd1;
            if ((state_q == LOAD && !src_valid) || (res_valid && !res_ready)) begin
                perf_stalls_d = perf_stalls_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: remaining-work model compared every cycle plus per-job literal checks.
module tb_sa_sequencer;

    localparam int ROWS = 4;
    localparam int IW   = 8;
    localparam int OW   = 32;
    localparam int KW   = 16;
    localparam int FC   = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic job_valid = 1'b0;
    logic [KW-1:0] job_k = '0;
    logic job_ready;
    logic src_valid = 1'b0;
    logic src_ready;
    logic [ROWS-1:0][IW-1:0] src_a = '0;
    logic [ROWS-1:0][IW-1:0] src_w = '0;
    logic core_inpvalid;
    logic [ROWS-1:0][IW-1:0] core_ain, core_win;
    logic [ROWS-1:0][OW-1:0] core_rout;
    logic [ROWS-1:0] core_rvalid;
    logic core_outread;
    logic res_valid;
    logic res_ready = 1'b1;
    logic [ROWS-1:0][OW-1:0] res_data;
    logic res_last, busy, done;
`ifdef SA_SEQ_PERFCNT_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    sa_sequencer #(
        .ROWS(ROWS), .INWIDTH(IW), .OUTWIDTH(OW), .KW(KW), .FLUSH_CYC(FC)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_k(job_k),
        .src_valid(src_valid), .src_ready(src_ready), .src_a(src_a), .src_w(src_w),
        .core_inpvalid(core_inpvalid), .core_ain(core_ain), .core_win(core_win),
        .core_rout(core_rout), .core_rvalid(core_rvalid), .core_outread(core_outread),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done)
`ifdef SA_SEQ_PERFCNT_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", nm);
    endtask

    // Core stand-in: result vectors tagged with job number and read index
    int jobno = 0;
    int rd_idx = 0;
    logic [ROWS-1:0] rvalid_mask = '1;
    assign core_rvalid = rvalid_mask;
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            core_rout[r] = {jobno[7:0], rd_idx[7:0], 8'(r), 8'hA5};
        end
    end

    // Model: work remaining in the current job (beats to load, flush cycles, rows to drain)
    int m_busy = 0, m_beats = 0, m_flush = 0, m_rows = 0;
    int cyc = 0;
    logic e_load, e_drain, e_fin;
    logic e_job_ready, e_src_ready, e_inp, e_res_valid, e_last, e_outread, e_busy, e_done;
    logic [ROWS-1:0][IW-1:0] e_ain, e_win;
    logic [ROWS-1:0][OW-1:0] e_res_data;

    always_comb begin
        e_load      = (m_busy != 0) && (m_beats > 0);
        e_drain     = (m_busy != 0) && (m_beats == 0) && (m_flush == 0) && (m_rows > 0);
        e_fin       = (m_busy != 0) && (m_beats == 0) && (m_flush == 0) && (m_rows == 0);
        e_job_ready = !rst && (m_busy == 0);
        e_src_ready = !rst && e_load;
        e_inp       = e_src_ready && src_valid;
        e_ain       = e_inp ? src_a : '0;
        e_win       = e_inp ? src_w : '0;
        e_res_valid = !rst && e_drain && (&core_rvalid);
        e_res_data  = (!rst && e_drain) ? core_rout : '0;
        e_last      = e_res_valid && (m_rows == 1);
        e_outread   = e_res_valid && res_ready;
        e_busy      = !rst && (m_busy != 0);
        e_done      = !rst && e_fin;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst && e_outread) rd_idx++;
        if (rst) begin
            m_busy = 0; m_beats = 0; m_flush = 0; m_rows = 0;
        end else if (m_busy == 0) begin
            if (job_valid) begin
                m_busy  = 1;
                m_beats = int'(job_k);
                m_flush = (job_k != 0) ? FC : 0;
                m_rows  = (job_k != 0) ? ROWS : 0;
                jobno++;
                rd_idx = 0;
            end
        end else if (m_beats > 0) begin
            if (src_valid) m_beats--;
        end else if (m_flush > 0) begin
            m_flush--;
        end else if (m_rows > 0) begin
            if ((&core_rvalid) && res_ready) m_rows--;
        end else begin
            m_busy = 0;
        end
    end

    // Observed events, sampled from the DUT on the falling edge
    int n_acc = 0, n_inp = 0, n_done = 0;
    int acc_cyc = 0, done_cyc = 0, first_inp = 0, last_inp = 0, first_res = -1, last_res = 0;
    int j_inp = 0, j_res = 0, j_last = 0, stall_outread = 0;
    logic snap_ok = 1'b0;
    logic [ROWS-1:0][OW-1:0] snap;

    always @(negedge clk) begin
        chk("job_ready", job_ready, e_job_ready);
        chk("src_ready", src_ready, e_src_ready);
        chk("core_inpvalid", core_inpvalid, e_inp);
        chk("core_ain", core_ain, e_ain);
        chk("core_win", core_win, e_win);
        chk("res_valid", res_valid, e_res_valid);
        chk("res_data", res_data, e_res_data);
        chk("res_last", res_last, e_last);
        chk("core_outread", core_outread, e_outread);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        if (job_ready && job_valid) begin
            n_acc++; acc_cyc = cyc;
            j_inp = 0; j_res = 0; j_last = 0; first_res = -1; snap_ok = 1'b0;
        end
        if (core_inpvalid) begin
            if (j_inp == 0) first_inp = cyc;
            last_inp = cyc; j_inp++; n_inp++;
        end
        if (res_valid && first_res < 0) first_res = cyc;
        if (res_valid && !res_ready) begin
            if (core_outread) stall_outread++;
            if (snap_ok) chk("stall_data_stable", res_data, snap);
            snap = res_data; snap_ok = 1'b1;
        end
        if (core_outread) begin
            j_res++; last_res = cyc;
            if (res_last) j_last++;
            $display("res  job=%0d row=%0d data=%h last=%0d", jobno, j_res - 1, res_data, res_last);
        end
        if (done) begin
            n_done++; done_cyc = cyc;
            $display("done job=%0d k=%0d beats=%0d results=%0d", jobno, job_k, j_inp, j_res);
        end
    end

    task automatic run_job(input int k, input int g1, input int g2, input int glen,
                           input int mcyc, input int stall, input bit hold);
        int acc0, done0, inp0, budget, b, gc1, gc2, dr;
        acc0 = n_acc; done0 = n_done; inp0 = n_inp;
        gc1 = 0; gc2 = 0; dr = 0; budget = 0;
        job_valid = 1'b1;
        job_k = KW'(k);
        while (n_acc == acc0 && budget < 200) begin
            @(posedge clk); #1; budget++;
        end
        if (n_acc == acc0) begin
            fail_now("accept_timeout");
            job_valid = 1'b0;
            return;
        end
        if (!hold) job_valid = 1'b0;
        budget = 0;
        while (n_done == done0 && budget < 500) begin
            b = n_inp - inp0;
            src_a = $urandom; src_w = $urandom;
            if (!e_load || b >= k) src_valid = 1'b0;
            else if (b == g1 && gc1 < glen) begin src_valid = 1'b0; gc1++; end
            else if (b == g2 && gc2 < glen) begin src_valid = 1'b0; gc2++; end
            else src_valid = 1'b1;
            if (e_drain) begin
                rvalid_mask = (dr < mcyc) ? 4'b1011 : 4'b1111;
                res_ready = (dr >= mcyc && dr < mcyc + stall) ? 1'b0 : 1'b1;
                dr++;
            end else begin
                rvalid_mask = '1;
                res_ready = 1'b1;
            end
            @(posedge clk); #1; budget++;
        end
        if (n_done == done0) fail_now("done_timeout");
        src_valid = 1'b0; res_ready = 1'b1; rvalid_mask = '1;
    endtask

    initial begin
        int inp0, acc0, d1, budget;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_release_job_ready", job_ready, 1'b1);
        @(posedge clk); #1;

        // Basic job: 4 beats back-to-back, 10 flush cycles, 4 results
        run_job(4, -1, -1, 0, 0, 0, 1'b0);
        chk("t1_inp_count", j_inp, 4);
        chk("t1_inp_back_to_back", last_inp - first_inp, 3);
        chk("t1_flush_gap", first_res - last_inp, FC + 1);
        chk("t1_res_count", j_res, 4);
        chk("t1_last_count", j_last, 1);
        chk("t1_done_after_last", done_cyc - last_res, 1);
        repeat (2) @(posedge clk); #1;

        // Empty job
        run_job(0, -1, -1, 0, 0, 0, 1'b0);
        chk("t2_done_latency", done_cyc - acc_cyc, 1);
        chk("t2_inp_count", j_inp, 0);
        chk("t2_res_count", j_res, 0);
        repeat (2) @(posedge clk); #1;

        // Source gaps of 3 cycles before beats 2 and 4
        run_job(6, 2, 4, 3, 0, 0, 1'b0);
        chk("t3_inp_count", j_inp, 6);
        chk("t3_load_span", last_inp - first_inp, 11);
`ifdef SA_SEQ_PERFCNT_EN
        chk("t3_perf_stalls", perf_stalls, 6);
`endif
        repeat (2) @(posedge clk); #1;

        // Partial core_rvalid for 2 drain cycles, then res_ready low for 5
        stall_outread = 0;
        run_job(2, -1, -1, 0, 2, 5, 1'b0);
        chk("t4_res_count", j_res, 4);
        chk("t4_stall_outread", stall_outread, 0);
        chk("t4_drain_span", last_res - first_res, 8);
        repeat (2) @(posedge clk); #1;

        // Reset after beat 2 of 8, then a normal job
        acc0 = n_acc; inp0 = n_inp; budget = 0;
        job_valid = 1'b1; job_k = 16'd8;
        while (n_acc == acc0 && budget < 50) begin @(posedge clk); #1; budget++; end
        job_valid = 1'b0;
        src_valid = 1'b1;
        while (n_inp - inp0 < 2 && budget < 100) begin @(posedge clk); #1; budget++; end
        src_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_beats_before_rst", n_inp - inp0, 2);
        @(negedge clk);
        chk("t5_job_ready_after_rst", job_ready, 1'b1);
        @(posedge clk); #1;
        run_job(2, -1, -1, 0, 0, 0, 1'b0);
        chk("t5_inp_count", j_inp, 2);
        chk("t5_res_count", j_res, 4);
        repeat (2) @(posedge clk); #1;

        // job_valid held through a busy job: next accept lands the cycle after done
        run_job(3, -1, -1, 0, 0, 0, 1'b1);
        d1 = done_cyc;
        run_job(2, -1, -1, 0, 0, 0, 1'b0);
        chk("t6_accept_after_done", acc_cyc - d1, 1);
        chk("t6_inp_count", j_inp, 2);
        chk("t6_res_count", j_res, 4);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sa_sequencer.md
SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 Parameter ROWS, default 8, array dimension; matches the core it drives.
REQ-002 Parameter INWIDTH, default 8, A/W element width.
REQ-003 Parameter OUTWIDTH, default 32, accumulator/result width.
REQ-004 Parameter KW, default 16, width of the job depth field.
REQ-005 Parameter FLUSH_CYC, default 3*ROWS-2, cycles from last input beat until the core's results are final.
REQ-006 clk  in  1  sole clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 job_valid / job_ready  in/out  1/1  job handshake; transfer when both are high.
REQ-009 job_k  in  KW  number of A/W beats (reduction depth) in the job.
REQ-010 src_valid / src_ready  in/out  1/1  operand stream handshake.
REQ-011 src_a, src_w  in  ROWS x INWIDTH  operand vectors, one beat each.
REQ-012 core_inpvalid  out  1; core_ain, core_win  out  ROWS x INWIDTH; feed to core.
REQ-013 core_rout  in  ROWS x OUTWIDTH; core_rvalid  in  ROWS; core_outread  out  1.
REQ-014 res_valid / res_ready  out/in  1/1; res_data  out  ROWS x OUTWIDTH; res_last  out  1.
REQ-015 busy  out  1; done  out  1, one-cycle pulse at job completion.

Function
REQ-016 FSM states: IDLE, LOAD, FLUSH, DRAIN, DONE; state register only, no other implicit state.
REQ-017 IDLE: job_ready=1; on job handshake, latch job_k; go to LOAD if job_k!=0, else go to DONE.
REQ-018 LOAD: src_ready=1; each src handshake drives core_inpvalid=1 with core_ain/core_win=src_a/src_w in the same cycle (combinational pass-through) and increments beat_cnt.
REQ-019 LOAD, src_valid=0: core_inpvalid=0, beat_cnt holds, no timeout.
REQ-020 LOAD exits to FLUSH in the cycle after the handshake with beat_cnt==job_k-1; exactly job_k beats are issued, never more.
REQ-021 FLUSH: src_ready=0, core_inpvalid=0; wait counter runs FLUSH_CYC cycles, then go to DRAIN.
REQ-022 DRAIN: result vector is valid when all ROWS bits of core_rvalid are high; res_valid = &core_rvalid; res_data = core_rout.
REQ-023 On res handshake, core_outread pulses high for exactly that cycle and row_cnt increments; res_last=1 on vector ROWS-1.
REQ-024 res_ready=0: res_valid and res_data hold stable; core_outread stays 0.
REQ-025 After ROWS vectors are drained, go to DONE; DONE lasts one cycle, done=1, then IDLE.
REQ-026 job_ready=0 in every state except IDLE; busy=1 in every state except IDLE.
REQ-027 Counters are KW bits (beat), clog2(FLUSH_CYC+1) bits (flush) and clog2(ROWS+1) bits (row); none wraps within a legal job.

Reset
REQ-028 rst returns FSM to IDLE and clears all counters and latched job_k, at any state including mid-LOAD and mid-DRAIN.
REQ-029 Output values while rst is held: job_ready=0, src_ready=0, core_inpvalid=0, core_outread=0, res_valid=0, res_last=0, busy=0, done=0; core_ain/core_win/res_data=0.
REQ-030 After rst is released, job_ready=1 in the following cycle.

Configuration
REQ-031 With SA_SEQ_PERFCNT_EN defined: outputs perf_cycles (32b, busy cycles of the last job) and perf_stalls (32b, LOAD cycles with src_valid=0 plus DRAIN cycles with res_valid&!res_ready). Both clear on job accept, freeze in DONE, and are reset by rst.
REQ-032 Without SA_SEQ_PERFCNT_EN, the ports and counters are absent; all other behaviour is identical.

Structure
REQ-033 Shared package sa_pkg holds the seq_state_t enum (IDLE, LOAD, FLUSH, DRAIN, DONE) and default ROWS/INWIDTH/OUTWIDTH constants.
REQ-034 One sub-module, sa_seq_cnt: a loadable up-counter with terminal-count flag, instantiated for the beat, flush and row counters.

Verification
REQ-035 ROWS=4, FLUSH_CYC=10, job_k=4, src always valid -> 4 core_inpvalid cycles back-to-back, 10 FLUSH cycles, 4 res beats with res_last on the 4th, then done pulse.
REQ-036 job_k=0 -> done one cycle after accept; core_inpvalid never asserts; no res beats.
REQ-037 job_k=6, src_valid low on beats 2 and 4 for 3 cycles each -> exactly 6 inpvalid pulses; perf_stalls=6 when SA_SEQ_PERFCNT_EN is defined.
REQ-038 DRAIN with res_ready=0 for 5 cycles -> res_data stable, core_outread=0 throughout; pulses once when res_ready rises.
REQ-039 rst asserted for 1 cycle mid-LOAD after beat 2 of 8 -> all outputs 0, IDLE; a new job_k=2 then completes normally.
REQ-040 job_valid held high during a busy job -> not accepted until the cycle after done; second job then runs to completion.
